// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational N-bit ALU: accepts one instruction per handshake,
// reads both operands from a local register file and writes the ALU result back two cycles later.
//
// state | meaning
// IDLE  | instr_ready high, waiting for a handshake
// ISSUE | operands and opcode on the ALU inputs, ALU settling
// WB    | data_valid written to regfile[rd] and result on the next edge
module alu_issue_ctrl #(
    parameter int N  = 32,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [RA-1:0] instr_rd,
    input  logic [RA-1:0] instr_rs0,
    input  logic [RA-1:0] instr_rs1,
    input  logic          instr_cin,
    input  logic          wr_en,
    input  logic [RA-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [RA-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic [2:0]    AOP,
    output logic [N-1:0]  reg_in0,
    output logic [N-1:0]  reg_in1,
    output logic          c_in,
    input  logic [N-1:0]  data_valid,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          illegal
);

    localparam int DEPTH = 1 << RA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t        state;
    logic [RA-1:0] rd_q;
    logic [N-1:0]  regs [DEPTH];
    logic          op_legal;

    always_comb op_legal = (instr_op != 3'b010) && (instr_op != 3'b111);

    assign instr_ready = (state == IDLE);
    assign rd_data     = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_q    <= '0;
            AOP     <= 3'b000;
            reg_in0 <= '0;
            reg_in1 <= '0;
            c_in    <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            if (wr_en) regs[wr_addr] <= wr_data;
            // Writeback is assigned after the preload so it wins on an address collision.
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (op_legal) begin
                            AOP     <= instr_op;
                            reg_in0 <= regs[instr_rs0];
                            reg_in1 <= regs[instr_rs1];
                            c_in    <= instr_cin;
                            rd_q    <= instr_rd;
                            state   <= ISSUE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: state <= WB;
                WB: begin
                    regs[rd_q] <= data_valid;
                    result     <= data_valid;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issuing side of the N-bit ALU operand/opcode interface. Accepts one instruction at a time over a valid/ready handshake and reads both operands from an internal register file. Drives AOP, reg_in0, reg_in1 and c_in to the combinational ALU, then captures data_valid back into the register file. Sits between the instruction source (testbench or future decoder) and the ALU.

Parameters:
N, 32, datapath width; must match the ALU's N.
RA, 3, register address width; the register file holds 2**RA entries of N bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
instr_valid  input  1  instruction present
instr_ready  output  1  controller can accept an instruction
instr_op  input  3  ALU opcode (AOP encoding)
instr_rd  input  RA  destination register
instr_rs0  input  RA  source register for reg_in0
instr_rs1  input  RA  source register for reg_in1
instr_cin  input  1  carry-in, forwarded as c_in
wr_en  input  1  external register preload strobe
wr_addr  input  RA  preload address
wr_data  input  N  preload data
rd_addr  input  RA  debug read address
rd_data  output  N  combinational read of regfile[rd_addr]
AOP  output  3  to ALU, registered
reg_in0  output  N  to ALU, registered
reg_in1  output  N  to ALU, registered
c_in  output  1  to ALU, registered
data_valid  input  N  result from ALU
result  output  N  last written-back result
done  output  1  one-cycle pulse on writeback
illegal  output  1  one-cycle pulse on rejected opcode

Behaviour:
- Legal opcodes: 000 pass, 001 NOT, 011 NAND, 100 NOR, 101 SUB, 110 ADD+cin.
- Illegal opcodes: 010 and 111.
- FSM states: IDLE, ISSUE, WB.
- instr_ready = 1 only in IDLE. A handshake occurs when instr_valid && instr_ready.
- IDLE + handshake + legal opcode:
  - Register AOP <= instr_op, reg_in0 <= regfile[rs0], reg_in1 <= regfile[rs1], c_in <= instr_cin, and latch rd.
  - Go to ISSUE.
- IDLE + handshake + illegal opcode:
  - illegal = 1 in the next cycle; stay in IDLE.
  - AOP, operands and regfile are unchanged; done is not asserted.
- ISSUE: ALU settle cycle. Go to WB.
- WB:
  - regfile[rd] <= data_valid and result <= data_valid.
  - done = 1 for the cycle after the WB edge, coincident with IDLE.
  - Go to IDLE.
- Latency: handshake at edge T, writeback at edge T+2, done high during cycle T+2..T+3. Throughput is one instruction per 3 cycles.
- AOP, reg_in0, reg_in1 and c_in hold stable from capture until the next accepted instruction. They are not cleared after WB.
- Operand read: no bypass. A wr_en in the same cycle as the handshake to rs0/rs1 gives the operand the old value.
- Preload: wr_en is honoured in every state.
  - If WB and wr_en target the same address in the same cycle, the WB data wins.
  - Different addresses are both written.
- All registers, including r0, are general purpose.
- Arithmetic is modulo 2**N (ALU-defined). The controller adds no width extension and no flags.
- rst (synchronous) resets:
  - state to IDLE;
  - AOP=000, reg_in0=0, reg_in1=0, c_in=0, result=0, done=0, illegal=0;
  - every regfile entry to 0.
- rst asserted in ISSUE or WB aborts the instruction: no writeback, no done. rst has priority over wr_en.
- instr_ready is 1 in the first cycle after rst deasserts.

Test Plan:
- Preload r1=5, r2=3; issue op=110, rd=3, rs0=1, rs1=2, cin=1 -> AOP=110, reg_in0=5, reg_in1=3 at T+1; done at T+2; result=9; rd_data(r3)=9.
- r1=5, r2=7, op=101, rd=4 -> result=0xFFFFFFFE, r4=0xFFFFFFFE. Then r1=0xF0F0F0F0, r2=0xFF00FF00, op=011 -> result=0x0FFF0FFF.
- op=111 with valid -> illegal pulse at T+1, no done, instr_ready high at T+1, regfile unchanged, AOP retains its previous value.
- instr_valid held high with three ADD instructions -> handshakes at T, T+3, T+6. In the WB cycle, wr_en to the same rd with 0xDEAD -> rd holds the ALU result, not 0xDEAD.
- Handshake with rs0=1 while wr_en writes r1=0x55 (old value 5) -> reg_in0=5 and the next read of r1 = 0x55.
- rst asserted during ISSUE of an ADD into r3 -> next cycle: all outputs 0, no done, r3 reads 0, instr_ready=1 after release.
